// File: rtl/mdu_iter.sv
// Purpose: radix-2 iterative multiply/divide unit with RV M-extension semantics and a 32-bit word mode.
// Latency: N+1 cycles from accept to out_valid (N = 32 in word mode, else XLEN); 1 cycle for divide-by-zero and overflow.
// Backpressure: result and out_valid hold in DONE until out_ready; in_ready only in IDLE, so operations never overlap.
module mdu_iter #(
    parameter int XLEN    = 64,
    parameter bit WORD_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int CW = $clog2(XLEN + 1);
    localparam int W2 = 2 * XLEN;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    // Sign-extend from bit 31 when the op is a word variant.
    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v, input logic w);
        logic [XLEN-1:0] r;
        r = v;
        if (w) begin
            for (int i = 32; i < XLEN; i++) begin
                r[i] = v[31];
            end
        end
        return r;
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            word_q, word_d;
    logic [W2-1:0]   a_q, a_d;       // multiplicand (shifts left) / dividend-then-quotient in low half
    logic [W2-1:0]   acc_q, acc_d;   // product accumulator / remainder in low half
    logic [XLEN-1:0] b_q, b_d;       // multiplier (shifts right) / divisor
    logic            negq_q, negq_d; // negate product or quotient at the end
    logic            negr_q, negr_d; // negate remainder at the end
    logic [XLEN-1:0] result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    // request decode
    logic            word_eff, sb1, sb2, sgn1, sgn2, neg1, neg2, div_zero, div_ovf;
    logic [2:0]      op_e;
    logic [XLEN-1:0] mask, min_neg, x1, x2, m1, m2, a_ld, fast_res;

    // iteration datapath
    logic [W2-1:0]   mul_acc, mul_full;
    logic [XLEN:0]   rem_sh, diff;
    logic            qbit, last;
    logic [XLEN-1:0] rem_nx, q_nx, fin_raw, fin_res;

    // Decode the incoming request into magnitudes, sign flags and the fast-path result.
    always_comb begin
        word_eff = word & WORD_EN;
        mask     = word_eff ? XLEN'(32'hFFFF_FFFF) : {XLEN{1'b1}};
        min_neg  = word_eff ? XLEN'(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        x1       = op1 & mask;
        x2       = op2 & mask;
        sb1      = word_eff ? op1[31] : op1[XLEN-1];
        sb2      = word_eff ? op2[31] : op2[XLEN-1];
        // Word-mode high multiplies collapse to MULW.
        op_e     = (word_eff && !op[2]) ? OP_MUL : op;
        sgn1     = (op_e == OP_MULH) || (op_e == OP_MULHSU) || (op_e == OP_DIV) || (op_e == OP_REM);
        sgn2     = (op_e == OP_MULH) || (op_e == OP_DIV) || (op_e == OP_REM);
        neg1     = sgn1 & sb1;
        neg2     = sgn2 & sb2;
        m1       = (neg1 ? -x1 : x1) & mask;
        m2       = (neg2 ? -x2 : x2) & mask;
        // Left-align a word dividend so the restoring loop always consumes from the top bit.
        a_ld     = (op_e[2] && word_eff) ? (m1 << (XLEN - 32)) : m1;
        div_zero = op_e[2] && (x2 == '0);
        div_ovf  = ((op_e == OP_DIV) || (op_e == OP_REM)) && (x1 == min_neg) && (x2 == mask);
        if (div_zero) begin
            fast_res = op_e[1] ? sext32(x1, word_eff) : {XLEN{1'b1}};
        end else begin
            fast_res = op_e[1] ? '0 : sext32(x1, word_eff);
        end
    end

    // One shift-add or restoring-subtract step, plus the signed result if this is the last step.
    always_comb begin
        mul_acc  = acc_q + (b_q[0] ? a_q : {W2{1'b0}});
        mul_full = negq_q ? -mul_acc : mul_acc;
        rem_sh   = {acc_q[XLEN-1:0], a_q[XLEN-1]};
        diff     = rem_sh - {1'b0, b_q};
        qbit     = ~diff[XLEN];
        rem_nx   = qbit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        q_nx     = {a_q[XLEN-2:0], qbit};
        case (op_q)
            OP_MUL:                      fin_raw = mul_full[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_raw = mul_full[W2-1:XLEN];
            OP_DIV, OP_DIVU:             fin_raw = negq_q ? -q_nx : q_nx;
            default:                     fin_raw = negr_q ? -rem_nx : rem_nx;
        endcase
        fin_res  = sext32(fin_raw, word_q);
        last     = (cnt_q == (word_q ? CW'(31) : CW'(XLEN - 1)));
    end

    // Next-state logic: accept, iterate, hold the result, and let flush override everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        word_d   = word_q;
        a_d      = a_q;
        acc_d    = acc_q;
        b_d      = b_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q && !flush) begin
                    op_d   = op_e;
                    word_d = word_eff;
                    cnt_d  = '0;
                    a_d    = W2'(a_ld);
                    b_d    = m2;
                    acc_d  = '0;
                    negq_d = neg1 ^ neg2;
                    negr_d = neg1;
                    if (div_zero || div_ovf) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    a_d   = {a_q[W2-1:XLEN], q_nx};
                    acc_d = {{XLEN{1'b0}}, rem_nx};
                end else begin
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                    acc_d = mul_acc;
                end
                if (last) begin
                    result_d = fin_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
        end
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            word_q      <= 1'b0;
            a_q         <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            word_q      <= word_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign result    = result_q;

endmodule
